mdu_hilo: RTL and testbench

//  Multi-cycle multiply/divide unit in the EX stage. Consumes the decoded 8-bit alucontrol

---
 rtl/mdu_hilo.sv | 132 +++++++++++++
 tb/tb_mdu_hilo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: one-cycle multiply, WIDTH-iteration restoring divide.
// Latency: mul and divide-by-zero done at accept+2, divide done at accept+WIDTH+1; stalls the pipe while busy.
module mdu_hilo #(
    parameter int              WIDTH        = 32,
    parameter int              OP_W         = 8,
    parameter logic [OP_W-1:0] EXE_MULT_OP  = OP_W'(8'h18),
    parameter logic [OP_W-1:0] EXE_MULTU_OP = OP_W'(8'h19),
    parameter logic [OP_W-1:0] EXE_DIV_OP   = OP_W'(8'h1A),
    parameter logic [OP_W-1:0] EXE_DIVU_OP  = OP_W'(8'h1B)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [OP_W-1:0]  alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b, rem, quo, dvs;
    logic             sgn, dbz, neg_q, neg_r;
    logic [CW-1:0]    cnt;

    logic             is_mul, is_div, is_signed, mdu_op, accept;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_n, quo_n;

    always_comb begin
        is_mul    = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_MULTU_OP);
        is_div    = (alucontrol == EXE_DIV_OP)  || (alucontrol == EXE_DIVU_OP);
        is_signed = (alucontrol == EXE_MULT_OP) || (alucontrol == EXE_DIV_OP);
        mdu_op    = start && (is_mul || is_div);
        accept    = (state == IDLE) && mdu_op && !annul;
        stall     = accept || (state == MUL) || (state == DIV);
        abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    // Sign-extend to 2*WIDTH so the truncated product is correct for both signednesses.
    always_comb begin
        ext_a = sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
        ext_b = sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
        prod  = ext_a * ext_b;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = shifted[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_a  <= '0;
            op_b  <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            sgn   <= 1'b0;
            dbz   <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (annul) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        op_a  <= a;
                        op_b  <= b;
                        sgn   <= is_signed;
                        dbz   <= is_div && (b == '0);
                        neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= is_signed && a[WIDTH-1];
                        rem   <= '0;
                        quo   <= abs_a;
                        dvs   <= abs_b;
                        cnt   <= '0;
                        // Divide-by-zero borrows the one-cycle MUL slot so it matches multiply latency.
                        state <= (is_div && (b != '0)) ? DIV : MUL;
                    end
                    MUL: begin
                        if (dbz) begin
                            hi <= op_a;
                            lo <= '1;
                        end else begin
                            {hi, lo} <= prod;
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                    DIV: begin
                        rem <= rem_n;
                        quo <= quo_n;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH-1)) begin
                            hi    <= neg_r ? -rem_n : rem_n;
                            lo    <= neg_q ? -quo_n : quo_n;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed-vector bench for mdu_hilo: latency, results, annul, reset and ignored starts.
module tb_mdu_hilo;
    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;
    localparam logic [7:0] OP_ADD   = 8'h20;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  alucontrol = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        annul = 1'b0;
    logic        stall, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_hilo dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller positions just after a negedge; this cycle is T (the accept cycle).
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input bit hold, input int lat,
                          input logic [31:0] eh, input logic [31:0] el);
        int  k;
        bit  got;
        start = 1'b1; alucontrol = op; a = av; b = bv; annul = 1'b0;
        #1 check({tag, ".stall_T"}, 64'(stall), 64'd1);
        k = 0; got = 1'b0;
        while (k < 60 && !got) begin
            @(negedge clk);
            k++;
            if (k == 1 && hold) begin
                a = 32'd100; b = 32'd100;
            end else begin
                start = 1'b0;
            end
            #1;
            if (k == 1) check({tag, ".stall_T1"}, 64'(stall), 64'd1);
            if (done) got = 1'b1;
        end
        check({tag, ".latency"}, 64'(k), 64'(lat));
        check({tag, ".hi"}, 64'(hi), 64'(eh));
        check({tag, ".lo"}, 64'(lo), 64'(el));
        check({tag, ".stall_done"}, 64'(stall), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        #1;
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.stall", 64'(stall), 64'd0);
        @(negedge clk); resetn = 1'b1;

        @(negedge clk); run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 2, 32'h1, 32'hFFFF_FFFE);
        @(negedge clk); run_op("mult",  OP_MULT,  32'hFFFF_FFFD, 32'd5, 1'b0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        @(negedge clk); run_op("divu",  OP_DIVU,  32'd100, 32'd7, 1'b0, 33, 32'd2, 32'd14);
        @(negedge clk); run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clk); run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 32'h0, 32'h8000_0000);
        @(negedge clk); run_op("div_zero", OP_DIV, 32'h0000_1234, 32'd0, 1'b0, 2, 32'h0000_1234, 32'hFFFF_FFFF);

        // Non-mdu code: no stall, no done, hi/lo keep their value.
        @(negedge clk);
        start = 1'b1; alucontrol = OP_ADD; a = 32'd1; b = 32'd2;
        #1 check("add.stall", 64'(stall), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("add.no_done", 64'(seen), 64'd0);
        check("add.hi_hold", 64'(hi), 64'h1234);
        check("add.lo_hold", 64'(lo), 64'hFFFF_FFFF);

        // Annul at T+10 of a divide, then a new MULTU at T+11.
        @(negedge clk);
        start = 1'b1; alucontrol = OP_DIV; a = 32'd1000; b = 32'd3;
        seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) annul = 1'b1;
            #1;
            if (done) seen = 1'b1;
        end
        @(negedge clk); #1;
        check("annul.no_done_win", 64'(seen), 64'd0);
        check("annul.done_T11", 64'(done), 64'd0);
        check("annul.hi_hold", 64'(hi), 64'h1234);
        check("annul.lo_hold", 64'(lo), 64'hFFFF_FFFF);
        run_op("after_annul", OP_MULTU, 32'd3, 32'd4, 1'b0, 2, 32'd0, 32'd12);

        // Reset asserted at T+5 of a divide.
        @(negedge clk);
        start = 1'b1; alucontrol = OP_DIV; a = 32'd1000; b = 32'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("rst_mid.stall_before", 64'(stall), 64'd1);
        resetn = 1'b0;
        #1;
        check("rst_mid.hi", 64'(hi), 64'd0);
        check("rst_mid.lo", 64'(lo), 64'd0);
        check("rst_mid.stall", 64'(stall), 64'd0);
        check("rst_mid.done", 64'(done), 64'd0);
        @(negedge clk); resetn = 1'b1;

        // Back-to-back MULTs; the first holds start high during MUL.
        @(negedge clk); run_op("b2b_1", OP_MULT, 32'd7, 32'hFFFF_FFFE, 1'b1, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
        @(negedge clk); run_op("b2b_2", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 1'b0, 2, 32'd0, 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
